// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma copy engine.
package mem_dma_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_HALFU = 3'b101;
  localparam logic [2:0] F3_BYTEU = 3'b100;

  // log2 of the element size in bytes for a given access size
  function automatic logic [1:0] mode_shift(input logic [2:0] f3);
    case (f3)
      F3_WORD:  return 2'd2;
      F3_HALFU: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Memory-to-memory copy engine on the data-memory port: one element per cycle,
// read issued in one cycle, written back the next using the memory's read latency.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          read_address,
  output logic [2:0]           funct3,
  input  logic [31:0]          read_data,
  output logic                 write_mem,
  output logic [31:0]          write_address,
  output logic [31:0]          write_data
);

  state_e               state_q, state_d;
  logic [2:0]           f3_q, f3_d;
  logic [31:0]          rd_addr_q, rd_addr_d;
  logic [31:0]          wr_addr_q, wr_addr_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 wvld_q;
  logic [31:0]          waddr_q;

  logic [1:0]  low_or;
  logic [2:0]  f3_new;
  logic [32:0] src_end;
  logic        overlap;
  logic [31:0] step;

  assign low_or  = src_addr[1:0] | dst_addr[1:0] | len[1:0];
  assign f3_new  = (low_or == 2'b00) ? F3_WORD : (!low_or[0] ? F3_HALFU : F3_BYTEU);
  // 33-bit end address so a source near the top of memory cannot wrap past dst
  assign src_end = {1'b0, src_addr} + {{(33-LEN_WIDTH){1'b0}}, len};
  assign overlap = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);
  assign step    = 32'd1 << mode_shift(f3_q);

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (len == '0) begin
          state_d = DONE;
        end else if (overlap) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d   = READ;
          f3_d      = f3_new;
          rd_addr_d = src_addr;
          wr_addr_d = dst_addr;
          cnt_d     = len >> mode_shift(f3_new);
        end
      end
      READ: begin
        rd_addr_d = rd_addr_q + step;
        wr_addr_d = wr_addr_q + step;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == LEN_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      f3_q      <= F3_WORD;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wvld_q    <= 1'b0;
      waddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      // write stage: the read issued this cycle returns data next cycle
      wvld_q    <= (state_q == READ);
      waddr_q   <= wr_addr_q;
    end
  end

  assign busy          = (state_q == READ) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign funct3        = f3_q;
  assign read_address  = (state_q == READ) ? rd_addr_q : 32'd0;
  assign write_mem     = wvld_q;
  assign write_address = wvld_q ? waddr_q : 32'd0;
  assign write_data    = wvld_q ? read_data : 32'd0;

endmodule
